// File: rtl/uart_fifo.sv
// UART with TX/RX FIFOs, runtime parity and stop-bit selection, and sticky line-error flags.
// Characters are DATA_BITS wide and sent LSB first. Each bit lasts bitperiod clocks (minimum 2).
module uart_fifo #(
  parameter int DATA_BITS = 8,
  parameter int TX_AW     = 4,
  parameter int RX_AW     = 4,
  parameter int RATE_W    = 16
) (
  input  logic                 clk,
  input  logic                 arst,
  output logic                 ready,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] din,
  output logic                 full,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] dout,
  input  logic [RATE_W-1:0]    bitperiod,
  input  logic [1:0]           parity,
  input  logic                 stop2,
  output logic [TX_AW:0]       tx_level,
  output logic [RX_AW:0]       rx_level,
  output logic [2:0]           err,
  input  logic                 err_clr,
  input  logic                 rxd,
  output logic                 txd
);

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_HUNT, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BRK} rx_state_t;

  // Divisors below 2 would leave no room for a mid-bit sample point.
  function automatic logic [RATE_W-1:0] eff_period(input logic [RATE_W-1:0] bp);
    return (bp < RATE_W'(2)) ? RATE_W'(2) : bp;
  endfunction

  function automatic logic par_on(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem_q [2**TX_AW];
  logic [TX_AW-1:0]     tx_wp_q, tx_rp_q;
  logic [TX_AW:0]       tx_lvl_q, tx_lvl_d;
  logic                 tx_push, tx_pop;

  assign ready    = ~tx_lvl_q[TX_AW];
  assign tx_push  = wr & ready;
  assign tx_level = tx_lvl_q;

  // Occupancy update with simultaneous push and pop.
  always_comb tx_lvl_d = tx_lvl_q + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);

  // TX storage array; holds data only, so it carries no reset.
  always_ff @(posedge clk) if (tx_push) tx_mem_q[tx_wp_q] <= din;

  // TX pointers and level.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_lvl_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + TX_AW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + TX_AW'(1);
      tx_lvl_q <= tx_lvl_d;
    end
  end

  // ---------------- TX line FSM ----------------
  tx_state_t            tx_st_q;
  logic [RATE_W-1:0]    tx_cnt_q;
  logic [IDX_W-1:0]     tx_idx_q;
  logic                 tx_paren_q, tx_stop2_q, tx_stp_q, txd_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_pbit_q;
  logic                 tx_last, tx_line;

  assign tx_last = (tx_cnt_q == '0);
  // Pop in IDLE, or at the very end of the last stop bit for back-to-back frames.
  assign tx_pop  = (tx_lvl_q != '0) &&
                   ((tx_st_q == TX_IDLE) ||
                    ((tx_st_q == TX_STOP) && tx_last && (tx_stp_q || !tx_stop2_q)));
  assign txd     = txd_q;

  // Line level implied by the current state; registered one cycle later into txd.
  always_comb begin
    tx_line = 1'b1;
    case (tx_st_q)
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_sh_q[0];
      TX_PAR:   tx_line = tx_pbit_q;
      default:  tx_line = 1'b1;
    endcase
  end

  // Character shifter and parity bit, loaded at the FIFO pop.
  always_ff @(posedge clk) begin
    if (tx_pop) begin
      tx_sh_q   <= tx_mem_q[tx_rp_q];
      tx_pbit_q <= (^tx_mem_q[tx_rp_q]) ^ (parity == 2'b10);
    end else if ((tx_st_q == TX_DATA) && tx_last) begin
      tx_sh_q <= tx_sh_q >> 1;
    end
  end

  // TX sequencing: bit counter reloads from bitperiod at every bit boundary.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      tx_st_q    <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_paren_q <= 1'b0;
      tx_stop2_q <= 1'b0;
      tx_stp_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      txd_q <= tx_line;
      if (tx_pop) begin
        tx_st_q    <= TX_START;
        tx_cnt_q   <= eff_period(bitperiod) - RATE_W'(1);
        tx_idx_q   <= '0;
        tx_paren_q <= par_on(parity);
        tx_stop2_q <= stop2;
        tx_stp_q   <= 1'b0;
      end else if (tx_st_q != TX_IDLE) begin
        if (!tx_last) begin
          tx_cnt_q <= tx_cnt_q - RATE_W'(1);
        end else begin
          tx_cnt_q <= eff_period(bitperiod) - RATE_W'(1);
          case (tx_st_q)
            TX_START: tx_st_q <= TX_DATA;
            TX_DATA:
              if (tx_idx_q == LAST_IDX) tx_st_q <= tx_paren_q ? TX_PAR : TX_STOP;
              else                      tx_idx_q <= tx_idx_q + IDX_W'(1);
            TX_PAR:   tx_st_q <= TX_STOP;
            TX_STOP:
              if (tx_stop2_q && !tx_stp_q) tx_stp_q <= 1'b1;
              else                         tx_st_q  <= TX_IDLE;
            default:  tx_st_q <= TX_IDLE;
          endcase
        end
      end
    end
  end

  // ---------------- RX line FSM ----------------
  rx_state_t            rx_st_q;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [RATE_W-1:0]    rx_cnt_q, rx_per_q;
  logic [IDX_W-1:0]     rx_idx_q;
  logic [1:0]           rx_par_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_samp, rx_end, rx_push, rx_ferr, rx_perr;

  assign rx_samp = (rx_cnt_q == (rx_per_q >> 1));
  assign rx_end  = (rx_cnt_q == rx_per_q - RATE_W'(1));
  assign rx_push = (rx_st_q == RX_STOP) && rx_samp;
  assign rx_ferr = rx_push && !rx_s2_q;
  assign rx_perr = (rx_st_q == RX_PAR) && rx_samp &&
                   (((^rx_sh_q) ^ rx_s2_q) != (rx_par_q == 2'b10));

  // Received bits enter at the top so the first bit ends up at bit 0.
  always_ff @(posedge clk) begin
    if ((rx_st_q == RX_DATA) && rx_samp) rx_sh_q <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
  end

  // Synchroniser, start-edge hunt and mid-bit sampling; bit counter counts up from the bit start.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= RX_HUNT;
      rx_cnt_q  <= '0;
      rx_per_q  <= RATE_W'(2);
      rx_idx_q  <= '0;
      rx_par_q  <= 2'b00;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      case (rx_st_q)
        RX_HUNT:
          if (rx_prev_q && !rx_s2_q) begin
            rx_st_q  <= RX_START;
            rx_cnt_q <= RATE_W'(1);
            rx_per_q <= eff_period(bitperiod);
            rx_par_q <= parity;
            rx_idx_q <= '0;
          end
        RX_START:
          if (rx_samp && rx_s2_q) rx_st_q <= RX_HUNT;
          else if (rx_end) begin
            rx_st_q  <= RX_DATA;
            rx_cnt_q <= '0;
            rx_per_q <= eff_period(bitperiod);
          end else rx_cnt_q <= rx_cnt_q + RATE_W'(1);
        RX_DATA:
          if (rx_end) begin
            rx_cnt_q <= '0;
            rx_per_q <= eff_period(bitperiod);
            if (rx_idx_q == LAST_IDX) rx_st_q <= par_on(rx_par_q) ? RX_PAR : RX_STOP;
            else                      rx_idx_q <= rx_idx_q + IDX_W'(1);
          end else rx_cnt_q <= rx_cnt_q + RATE_W'(1);
        RX_PAR:
          if (rx_end) begin
            rx_st_q  <= RX_STOP;
            rx_cnt_q <= '0;
            rx_per_q <= eff_period(bitperiod);
          end else rx_cnt_q <= rx_cnt_q + RATE_W'(1);
        RX_STOP:
          if (rx_samp) rx_st_q <= rx_s2_q ? RX_HUNT : RX_BRK;
          else         rx_cnt_q <= rx_cnt_q + RATE_W'(1);
        RX_BRK:
          if (rx_s2_q) rx_st_q <= RX_HUNT;
        default: rx_st_q <= RX_HUNT;
      endcase
    end
  end

  // ---------------- RX FIFO and error flags ----------------
  logic [DATA_BITS-1:0] rx_mem_q [2**RX_AW];
  logic [RX_AW-1:0]     rx_wp_q, rx_rp_q;
  logic [RX_AW:0]       rx_lvl_q, rx_lvl_d;
  logic [2:0]           err_q, err_d;
  logic                 rx_pop, rx_wr, rx_ovr;

  assign full     = (rx_lvl_q != '0);
  assign rx_pop   = rd & full;
  // A pop in the same cycle frees the slot the incoming character needs.
  assign rx_wr    = rx_push & (~rx_lvl_q[RX_AW] | rx_pop);
  assign rx_ovr   = rx_push & rx_lvl_q[RX_AW] & ~rx_pop;
  assign dout     = full ? rx_mem_q[rx_rp_q] : '0;
  assign rx_level = rx_lvl_q;
  assign err      = err_q;

  // Level and sticky flags; a fresh error overrides a clear in the same cycle.
  always_comb begin
    rx_lvl_d = rx_lvl_q + (RX_AW+1)'(rx_wr) - (RX_AW+1)'(rx_pop);
    err_d    = (err_clr ? 3'b000 : err_q) | {rx_ovr, rx_perr, rx_ferr};
  end

  // RX storage array; data only, no reset.
  always_ff @(posedge clk) if (rx_wr) rx_mem_q[rx_wp_q] <= rx_sh_q;

  // RX pointers, level and error register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_lvl_q <= '0;
      err_q    <= 3'b000;
    end else begin
      if (rx_wr)  rx_wp_q <= rx_wp_q + RX_AW'(1);
      if (rx_pop) rx_rp_q <= rx_rp_q + RX_AW'(1);
      rx_lvl_q <= rx_lvl_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed and randomized bench for uart_fifo with a frame-level reference model.
module tb_uart_fifo;

  logic        clk = 1'b0;
  logic        arst, wr, rd, stop2, err_clr, rxd_drv, loop, cap;
  logic [7:0]  din, dout;
  logic [15:0] bitperiod;
  logic [1:0]  parity;
  logic        ready, full, txd;
  logic [4:0]  tx_level, rx_level;
  logic [2:0]  err;
  wire         rxd_w = loop ? txd : rxd_drv;

  int   n_chk = 0;
  int   n_fail = 0;
  logic txq[$];

  always #5 clk = ~clk;

  uart_fifo dut (
    .clk(clk), .arst(arst), .ready(ready), .wr(wr), .din(din), .full(full), .rd(rd),
    .dout(dout), .bitperiod(bitperiod), .parity(parity), .stop2(stop2),
    .tx_level(tx_level), .rx_level(rx_level), .err(err), .err_clr(err_clr),
    .rxd(rxd_w), .txd(txd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cap) txq.push_back(txd);
  endtask

  function automatic logic bit_of(input logic [31:0] v, input int k);
    logic [31:0] t;
    t = v >> k;
    return t[0];
  endfunction

  // Expected line level of bit b of a frame: start, 8 data LSB first, optional parity, stop(s).
  function automatic logic frame_bit(input logic [7:0] d, input logic [1:0] p, input int b);
    int ones;
    if (b == 0) return 1'b0;
    if (b <= 8) return bit_of(32'(d), b - 1);
    if (b == 9 && (p == 2'b01 || p == 2'b10)) begin
      ones = $countones(d);
      return ((ones % 2) == 1) ^ (p == 2'b10);
    end
    return 1'b1;
  endfunction

  task automatic send_rx(input logic [7:0] d, input bit has_par, input bit pbit,
                         input bit stopv, input bit rd_at, input int bp);
    rxd_drv = 1'b0;
    repeat (bp) tick();
    for (int i = 0; i < 8; i++) begin
      rxd_drv = bit_of(32'(d), i);
      repeat (bp) tick();
    end
    if (has_par) begin
      rxd_drv = pbit;
      repeat (bp) tick();
    end
    rxd_drv = stopv;
    // Synchroniser adds two cycles; the stop sample lands bp/2 counts into the stop bit.
    for (int c = 0; c < bp + 4; c++) begin
      rd = rd_at && (c == 2 + bp / 2);
      tick();
    end
    rd = 1'b0;
  endtask

  task automatic wait_rx(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (rx_level != 5'(target) && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(rx_level), 32'(target));
  endtask

  task automatic write_tx(input logic [7:0] d);
    din = d;
    wr  = 1'b1;
    tick();
    wr  = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  first;
    logic [9:0]  t1;
    logic [1:0]  p;
    int          bp, s, k;

    arst = 1'b1; wr = 1'b0; rd = 1'b0; din = '0; bitperiod = 16'd4; parity = 2'b00;
    stop2 = 1'b0; err_clr = 1'b0; rxd_drv = 1'b1; loop = 1'b0; cap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_txlvl", 32'(tx_level), 32'd0);
    check("rst_rxlvl", 32'(rx_level), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_txd", 32'(txd), 32'd1);
    arst = 1'b0;
    repeat (3) tick();

    // Test 1: exact TX waveform of 0xA5 at bitperiod 4.
    t1 = 10'b1101001010;
    write_tx(8'hA5);
    for (int i = 0; i < 46; i++) begin
      if (i < 2 || i >= 42) check("t1_idle", 32'(txd), 32'd1);
      else                  check("t1_bit", 32'(txd), 32'(bit_of(32'(t1), (i - 2) / 4)));
      tick();
    end

    // Test 2: loopback, odd parity, bitperiod 5.
    loop = 1'b1; bitperiod = 16'd5; parity = 2'b10;
    q = '{8'h00, 8'hFF, 8'h3C};
    foreach (q[i]) write_tx(q[i]);
    wait_rx(3, 700, "t2_level");
    check("t2_err", 32'(err), 32'd0);
    foreach (q[i]) begin
      check("t2_dout", 32'(dout), 32'(q[i]));
      rd = 1'b1; tick(); rd = 1'b0;
    end
    check("t2_empty", 32'(full), 32'd0);
    repeat (30) tick();

    // Randomized loopback batches with random divisor, parity and stop bits.
    for (int b = 0; b < 4; b++) begin
      bitperiod = 16'($urandom_range(0, 9));
      parity    = 2'($urandom_range(0, 3));
      stop2     = 1'($urandom_range(0, 1));
      q.delete();
      for (int i = 0; i < 6; i++) begin
        q.push_back(8'($urandom));
        write_tx(q[i]);
      end
      wait_rx(6, 1200, "rnd_level");
      check("rnd_err", 32'(err), 32'd0);
      foreach (q[i]) begin
        check("rnd_dout", 32'(dout), 32'(q[i]));
        rd = 1'b1; tick(); rd = 1'b0;
      end
      repeat (40) tick();
    end

    // Test 3: fill TX FIFO while a frame is on the line, then check back-to-back output.
    loop = 1'b0; rxd_drv = 1'b1; bitperiod = 16'd4; parity = 2'b00; stop2 = 1'b0;
    repeat (40) tick();
    txq.delete(); cap = 1'b1;
    first = 8'h5A;
    write_tx(first);
    k = 0;
    while (tx_level != 5'd0 && k < 10) begin tick(); k++; end
    check("t3_popped", 32'(tx_level), 32'd0);
    q.delete();
    for (int i = 0; i < 17; i++) begin
      check("t3_ready", 32'(ready), (i < 16) ? 32'd1 : 32'd0);
      if (i < 16) q.push_back(8'($urandom));
      write_tx((i < 16) ? q[i] : 8'hEE);
    end
    check("t3_txlvl", 32'(tx_level), 32'd16);
    check("t3_notready", 32'(ready), 32'd0);
    repeat (17 * 40 + 20) tick();
    cap = 1'b0;
    s = -1;
    foreach (txq[i]) if (s < 0 && txq[i] === 1'b0) s = i;
    check("t3_start", 32'(s >= 0), 32'd1);
    if (s >= 0) begin
      for (int f = 0; f < 17; f++)
        for (int bi = 0; bi < 10; bi++)
          check("t3_bit", 32'(txq[s + (f * 10 + bi) * 4 + 2]),
                32'(frame_bit((f == 0) ? first : q[f - 1], 2'b00, bi)));
      check("t3_idle", 32'(txq[s + 170 * 4 + 2]), 32'd1);
    end
    check("t3_drained", 32'(tx_level), 32'd0);

    // Test 4: RX overrun with no reads, then full-plus-read in the same cycle.
    bitperiod = 16'd6;
    q.delete();
    for (int i = 0; i < 17; i++) begin
      q.push_back(8'($urandom));
      send_rx(q[i], 1'b0, 1'b0, 1'b1, 1'b0, 6);
    end
    check("t4_level", 32'(rx_level), 32'd16);
    check("t4_ovr", 32'(err), 32'b100);
    for (int i = 0; i < 16; i++) begin
      check("t4_dout", 32'(dout), 32'(q[i]));
      rd = 1'b1; tick(); rd = 1'b0;
    end
    check("t4_empty", 32'(full), 32'd0);
    pulse_clr();
    check("t4_clr", 32'(err), 32'd0);
    q.delete();
    for (int i = 0; i < 17; i++) begin
      q.push_back(8'($urandom));
      send_rx(q[i], 1'b0, 1'b0, 1'b1, (i == 16), 6);
    end
    check("t4b_level", 32'(rx_level), 32'd16);
    check("t4b_err", 32'(err), 32'd0);
    for (int i = 1; i < 17; i++) begin
      check("t4b_dout", 32'(dout), 32'(q[i]));
      rd = 1'b1; tick(); rd = 1'b0;
    end

    // Test 5: parity and framing errors; character still pushed.
    parity = 2'b01;
    send_rx(8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 6);
    check("t5_perr", 32'(err), 32'b010);
    check("t5_pdout", 32'(dout), 32'h01);
    rd = 1'b1; tick(); rd = 1'b0;
    pulse_clr();
    send_rx(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 6);
    check("t5_pok", 32'(err), 32'd0);
    rd = 1'b1; tick(); rd = 1'b0;
    parity = 2'b00;
    send_rx(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 6);
    repeat (30) tick();
    check("t5_ferr", 32'(err), 32'b001);
    check("t5_flevel", 32'(rx_level), 32'd1);
    check("t5_fdout", 32'(dout), 32'h55);
    rxd_drv = 1'b1;
    repeat (10) tick();
    pulse_clr();
    check("t5_clr", 32'(err), 32'd0);
    send_rx(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 6);
    check("t5_level2", 32'(rx_level), 32'd2);
    rd = 1'b1; tick(); rd = 1'b0;
    check("t5_after", 32'(dout), 32'h3C);
    rd = 1'b1; tick(); rd = 1'b0;

    // Test 6: short glitch is not a start bit.
    bitperiod = 16'd16;
    rxd_drv = 1'b0;
    repeat (4) tick();
    rxd_drv = 1'b1;
    repeat (60) tick();
    check("t6_glitch", 32'(rx_level), 32'd0);
    check("t6_gerr", 32'(err), 32'd0);

    // Reset in the middle of a TX start bit with both FIFOs occupied.
    bitperiod = 16'd6;
    send_rx(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 6);
    bitperiod = 16'd4;
    write_tx(8'hC3);
    write_tx(8'h11);
    tick();
    check("t6_pre_txd", 32'(txd), 32'd0);
    check("t6_pre_lvl", 32'(tx_level), 32'd1);
    arst = 1'b1;
    #1;
    check("t6_txd", 32'(txd), 32'd1);
    check("t6_txlvl", 32'(tx_level), 32'd0);
    check("t6_rxlvl", 32'(rx_level), 32'd0);
    check("t6_ready", 32'(ready), 32'd1);
    check("t6_dout", 32'(dout), 32'd0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    repeat (20) begin
      tick();
      if (txd !== 1'b1) check("t6_post_txd", 32'(txd), 32'd1);
    end
    check("t6_post_lvl", 32'(tx_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
